// File: rtl/fifod2mac.sv
// rtl/fifod2mac.sv - fifod to mac UDP transmit stage: header + payload framer
module fifod2mac #(
  parameter logic [7:0]  HDR0    = 8'h55,
  parameter logic [7:0]  HDR1    = 8'hAA,
  parameter logic [11:0] MAX_LEN = 12'd1468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [11:0] data_len,
  input  logic [7:0]  dev_info,
  output logic [11:0] udp_tx_len,
  input  logic        flag_udp_tx_prep,
  output logic        flag_udp_tx_req,
  input  logic        udp_txen,
  output logic [7:0]  udp_txd,
  output logic        fifod_rxen,
  input  logic [7:0]  fifod_rxd,
  input  logic        fifod_empty
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, REQ, SEND, DONE} state_t;

  state_t      state;
  logic [11:0] idx;       // byte index within the frame
  logic [7:0]  dev;       // dev_info latched at start
  logic [7:0]  cnt;       // frame counter
  logic [7:0]  byte_q;    // registered header / zero byte
  logic        sel_fifo;  // deliver fifod_rxd instead of byte_q this cycle
  logic [11:0] len_c;
  logic        consume;

  // Payload length clamped to what fits in one UDP frame
  always_comb begin
    len_c = (data_len > MAX_LEN) ? MAX_LEN : data_len;
  end

  // A byte is taken only while sending and the frame is not yet complete
  assign consume    = (state == SEND) && udp_txen && (idx < udp_tx_len);
  assign fifod_rxen = consume && (idx >= 12'd4) && !fifod_empty;

  // fifod data arrives one cycle after the read, matching the registered header path
  assign udp_txd = sel_fifo ? fifod_rxd : byte_q;

  // Frame sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      fd              <= 1'b0;
      err             <= 1'b0;
      flag_udp_tx_req <= 1'b0;
      udp_tx_len      <= 12'd0;
      idx             <= 12'd0;
      dev             <= 8'h00;
      cnt             <= 8'h00;
      byte_q          <= 8'h00;
      sel_fifo        <= 1'b0;
    end else begin
      flag_udp_tx_req <= 1'b0;
      byte_q          <= 8'h00;
      sel_fifo        <= 1'b0;
      case (state)
        IDLE: begin
          if (fs) state <= LOAD;
        end
        LOAD: begin
          udp_tx_len <= len_c + 12'd4;
          err        <= (data_len > MAX_LEN);
          dev        <= dev_info;
          idx        <= 12'd0;
          state      <= WAIT;
        end
        WAIT: begin
          if (flag_udp_tx_prep) begin
            flag_udp_tx_req <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          state <= SEND;
        end
        SEND: begin
          if (consume) begin
            idx <= idx + 12'd1;
            case (idx)
              12'd0:   byte_q <= HDR0;
              12'd1:   byte_q <= HDR1;
              12'd2:   byte_q <= dev;
              12'd3:   byte_q <= cnt;
              default: begin
                // Underflow keeps the frame length: send a zero and flag it
                if (fifod_empty) err <= 1'b1;
                else             sel_fifo <= 1'b1;
              end
            endcase
          end else if (idx == udp_tx_len) begin
            fd    <= 1'b1;
            cnt   <= cnt + 8'd1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!fs) begin
            fd    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifod2mac.sv
// tb/tb_fifod2mac.sv - self-checking bench for fifod2mac
module tb_fifod2mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs;
  logic        fd;
  logic        err;
  logic [11:0] data_len;
  logic [7:0]  dev_info;
  logic [11:0] udp_tx_len;
  logic        flag_udp_tx_prep;
  logic        flag_udp_tx_req;
  logic        udp_txen;
  logic [7:0]  udp_txd;
  logic        fifod_rxen;
  logic [7:0]  fifod_rxd;
  logic        fifod_empty;

  fifod2mac dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .err(err),
    .data_len(data_len), .dev_info(dev_info), .udp_tx_len(udp_tx_len),
    .flag_udp_tx_prep(flag_udp_tx_prep), .flag_udp_tx_req(flag_udp_tx_req),
    .udp_txen(udp_txen), .udp_txd(udp_txd), .fifod_rxen(fifod_rxen),
    .fifod_rxd(fifod_rxd), .fifod_empty(fifod_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dlen; int dev; int nfifo; bit seq; bit gap; int pdly; int exp_len; int exp_err;
  } vec_t;

  vec_t     tbl[9];
  int       checks = 0;
  int       passed = 0;
  int       rx_cnt = 0;
  bit [7:0] cnt_model = 8'h00;
  logic [7:0] q[$];
  int       exp_b[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  // One clock: inputs already set; models the 1-cycle-latency FIFO; returns at negedge
  task automatic tick();
    bit rd;
    fifod_empty = (q.size() == 0);
    #1;
    rd = fifod_rxen;
    @(posedge clk);
    #1;
    if (rd && q.size() > 0) fifod_rxd = q.pop_front();
    rx_cnt += int'(rd);
    fifod_empty = (q.size() == 0);
    @(negedge clk);
  endtask

  // Start a frame, wait for the request; returns observed latency (0 = none)
  task automatic start_frame(input int dlen, input int dev, input int nfifo, input bit seq,
                             input int pdly, output int lat);
    bit got = 0;
    q.delete();
    for (int i = 0; i < nfifo; i++) q.push_back(seq ? 8'(i) : 8'($urandom));
    data_len = 12'(dlen);
    dev_info = 8'(dev);
    fs = 1'b1;
    rx_cnt = 0;
    lat = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      flag_udp_tx_prep = (c >= pdly);
      tick();
      lat++;
      if (flag_udp_tx_req) got = 1;
    end
    if (!got) lat = 0;
    flag_udp_tx_prep = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int L, exl, exerr, lat, idx, mism, budget, mact;
    L     = (v.dlen > 1468) ? 1468 : v.dlen;
    exl   = (v.exp_len >= 0) ? v.exp_len : L + 4;
    exerr = (v.exp_err >= 0) ? v.exp_err : int'(v.dlen > 1468 || v.nfifo < L);
    start_frame(v.dlen, v.dev, v.nfifo, v.seq, v.pdly, lat);
    // expected frame: header then FIFO bytes in order, zeros once FIFO runs dry
    exp_b.delete();
    exp_b.push_back(8'h55); exp_b.push_back(8'hAA);
    exp_b.push_back(v.dev); exp_b.push_back(int'(cnt_model));
    for (int i = 0; i < L; i++) exp_b.push_back(i < q.size() ? int'(q[i]) : 0);
    chk("req_latency", lat, (v.pdly + 1 > 3) ? v.pdly + 1 : 3);
    chk("udp_tx_len", int'(udp_tx_len), exl);
    tick();
    chk("req_one_cycle", int'(flag_udp_tx_req), 0);
    if (v.gap) fs = 1'b0;
    idx = 0; mism = -1; mact = 0; budget = 4000;
    while (idx < exl && budget > 0) begin
      bit t;
      t = v.gap ? 1'($urandom_range(0, 1)) : 1'b1;
      udp_txen = t;
      tick();
      budget--;
      if (t) begin
        if (mism < 0 && int'(udp_txd) != exp_b[idx]) begin mism = idx; mact = int'(udp_txd); end
        idx++;
      end
    end
    chk("frame_bytes_delivered", idx, exl);
    if (mism >= 0) $display("FAIL byte[%0d] actual=%02h expected=%02h", mism, mact, exp_b[mism]);
    chk("frame_first_bad_index", mism, -1);
    chk("fd_not_early", int'(fd), 0);
    udp_txen = 1'b1;
    tick();
    chk("fd_after_last", int'(fd), 1);
    chk("txd_after_last", int'(udp_txd), 0);
    chk("err", int'(err), exerr);
    chk("rxen_count", rx_cnt, (L < v.nfifo) ? L : v.nfifo);
    udp_txen = 1'b0;
    fs = 1'b0;
    tick();
    chk("fd_clear", int'(fd), 0);
    cnt_model++;
  endtask

  initial begin
    int lat;
    vec_t r;
    tbl[0] = '{16,   8'h3C, 16,   1, 0, 0, 20,   0};
    tbl[1] = '{16,   8'h3C, 16,   1, 0, 0, 20,   0};
    tbl[2] = '{0,    8'h11, 0,    1, 0, 1, 4,    0};
    tbl[3] = '{2000, 8'h22, 2000, 0, 0, 2, 1472, 1};
    tbl[4] = '{6,    8'h33, 3,    1, 0, 0, 10,   1};
    tbl[5] = '{12,   8'h44, 12,   0, 1, 4, 16,   0};
    tbl[6] = '{1468, 8'h55, 1468, 0, 0, 3, 1472, 0};
    tbl[7] = '{1469, 8'h66, 1469, 0, 0, 0, 1472, 1};
    tbl[8] = '{5,    8'h77, 0,    0, 1, 1, 9,    1};

    rst_n = 1'b0; fs = 1'b0; data_len = '0; dev_info = '0; flag_udp_tx_prep = 1'b0;
    udp_txen = 1'b0; fifod_rxd = 8'h00; fifod_empty = 1'b1;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_fd", int'(fd), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_req", int'(flag_udp_tx_req), 0);
    chk("rst_rxen", int'(fifod_rxen), 0);
    chk("rst_txd", int'(udp_txd), 0);
    chk("rst_tx_len", int'(udp_tx_len), 0);
    udp_txen = 1'b1;
    tick();
    chk("idle_txen_txd", int'(udp_txd), 0);
    chk("idle_txen_rxen", int'(fifod_rxen), 0);
    udp_txen = 1'b0;

    for (int i = 0; i < 9; i++) run_frame(tbl[i]);

    // randomized frames checked by the model
    for (int i = 0; i < 25; i++) begin
      r.dlen  = $urandom_range(0, 40);
      r.dev   = $urandom_range(0, 255);
      r.nfifo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r.dlen) : r.dlen;
      r.seq   = 0;
      r.gap   = 1'($urandom_range(0, 1));
      r.pdly  = $urandom_range(0, 4);
      r.exp_len = -1;
      r.exp_err = -1;
      run_frame(r);
    end

    // frame counter wrap: enough header-only frames to pass 0xFF
    r = '{0, 8'h01, 0, 0, 0, 0, -1, -1};
    for (int i = 0; i < 256; i++) run_frame(r);
    run_frame(tbl[0]);

    // reset mid-SEND with gapped udp_txen and an underflow already flagged
    start_frame(16, 8'h3C, 2, 1, 0, lat);
    chk("rst_seq_req", int'(lat > 0), 1);
    tick();
    for (int i = 0; i < 14; i++) begin
      udp_txen = (i % 3 != 2);
      tick();
    end
    chk("rst_seq_err_before", int'(err), 1);
    rst_n = 1'b0; udp_txen = 1'b1; fs = 1'b0;
    tick();
    chk("midrst_fd", int'(fd), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_req", int'(flag_udp_tx_req), 0);
    chk("midrst_rxen", int'(fifod_rxen), 0);
    chk("midrst_txd", int'(udp_txd), 0);
    chk("midrst_tx_len", int'(udp_tx_len), 0);
    rst_n = 1'b1; udp_txen = 1'b0;
    cnt_model = 8'h00;
    tick();
    run_frame(tbl[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifod2mac.md
# fifod2mac

Transmit-side stage between the ADC data FIFO (fifod) and the UDP transmit port of `mac`. On a start flag from `cs` it requests a UDP transmission and streams a 4-byte frame header followed by `data_len` payload bytes read from fifod, then reports completion. It runs in the `gmii_txc` domain and is the producer for `udp_txd`, `eth_tx_len` and `flag_udp_tx_req`.

## Interface
Parameters:
- `HDR0`, 8'h55, first header byte (sync).
- `HDR1`, 8'hAA, second header byte (sync).
- `MAX_LEN`, 12'd1468, payload clamp; frame ≤ 1472 UDP bytes.

Ports:
- `clk` in 1, transmit clock (`gmii_txc`).
- `rst_n` in 1, synchronous active-low reset.
- `fs` in 1, start level from `cs`.
- `fd` out 1, done level to `cs`.
- `err` out 1, sticky underflow/clamp error, cleared on next accepted `fs`.
- `data_len` in 12, payload byte count, sampled at start.
- `dev_info` in 8, header byte 2, sampled at start.
- `udp_tx_len` out 12, UDP payload length to `mac` (= payload + 4).
- `flag_udp_tx_prep` in 1, `mac` ready to accept a request.
- `flag_udp_tx_req` out 1, one-cycle transmit request.
- `udp_txen` in 1, `mac` byte request strobe.
- `udp_txd` out 8, byte to `mac`.
- `fifod_rxen` out 1, fifod read enable.
- `fifod_rxd` in 8, fifod read data (1-cycle latency).
- `fifod_empty` in 1, fifod empty.

## Operation
- States: IDLE, LOAD, WAIT, REQ, SEND, DONE.
- IDLE: all strobes low. `fs`=1 → LOAD.
- LOAD (1 cycle): `len` = min(`data_len`, `MAX_LEN`); `err` set if clamped, else cleared; latch `dev_info`; `udp_tx_len` ← `len`+4; byte index ← 0. → WAIT.
- WAIT: hold until `flag_udp_tx_prep`=1 → REQ.
- REQ: `flag_udp_tx_req`=1 for exactly one cycle → SEND.
- SEND: each cycle with `udp_txen`=1 and index < `len`+4 consumes one byte and increments index. Byte order: index 0 `HDR0`, 1 `HDR1`, 2 latched `dev_info`, 3 frame counter, 4..`len`+3 fifod bytes in order. When index reaches `len`+4 → DONE.
- `fifod_rxen` = `udp_txen` & (state==SEND) & (4 ≤ index < `len`+4) & !`fifod_empty`.
- Underflow: payload byte requested while `fifod_empty`=1 → no read, byte sent as 8'h00, `err` set, index still advances (frame length preserved).
- `udp_txen` outside SEND or after last byte: ignored, no FIFO read, `udp_txd` = 8'h00.
- DONE: `fd`=1 until `fs`=0, then → IDLE. Frame counter increments (mod 256) on entry to DONE.
- `len`=0: header-only frame, no FIFO reads.
- `fs` dropping before DONE is ignored; frame completes.
- Width rules: index 12-bit; `len`+4 ≤ 1472 never overflows.

## Timing
- Reset (`rst_n`=0 at rising `clk`): state IDLE; `fd`, `err`, `flag_udp_tx_req`, `fifod_rxen` = 0; `udp_txd` = 8'h00; `udp_tx_len` = 0; frame counter = 0. Reset mid-frame abandons the frame; fifod is not drained (fifod reset owned by `cs`).
- `fs` rise sampled at cycle N → LOAD at N+1, `udp_tx_len` valid N+2, earliest `flag_udp_tx_req` N+3 (if `flag_udp_tx_prep` already high).
- Byte delivery: `udp_txen` high in cycle K → `udp_txd` valid in cycle K+1 for every byte (header bytes from register, payload from `fifod_rxd` via registered select). Back-to-back `udp_txen` gives one byte per cycle.
- `fd` asserts the cycle after the cycle delivering the last byte; `udp_tx_len` holds until next LOAD.

## Test plan
- Normal: `data_len`=16, fifod preloaded 0x00..0x0F, `dev_info`=0x3C, continuous `udp_txen` → `udp_tx_len`=20, one-cycle req, bytes 55 AA 3C 00 00..0F, `fd`=1, `err`=0.
- Second frame with same stimulus → byte 3 = 0x01; after 256 frames counter wraps to 0x00.
- `data_len`=0 → `udp_tx_len`=4, 4 header bytes, `fifod_rxen` never asserted.
- `data_len`=2000 → `udp_tx_len`=1472, 1468 FIFO reads, `err`=1.
- fifod holds 3 bytes, `data_len`=6 → payload 3 data bytes then 00 00 00, `err`=1, `fd` still asserts.
- `rst_n` pulsed low mid-SEND with gapped `udp_txen` → all outputs at reset values next cycle; new `fs` produces correct frame with counter 0x00.
